// File: rtl/bcd_7seg_scan_driver.sv
// bcd_7seg_scan_driver: time-multiplexed common-anode 7-segment driver
// for NUM_DIGITS packed BCD digits, with per-frame snapshot and
// leading-zero blanking.
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   digits_in   packed BCD, digit k = [4k+3:4k], digit 0 least significant
//   blank_lz    1 = blank leading zeros (sampled once per frame)
//   seg         segments {g,f,e,d,c,b,a}
//   an          one-hot digit enable, bit k = digit k
//   frame_start one-cycle pulse when a new snapshot is taken
module bcd_7seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

  localparam logic [6:0] SEG_OFF =
    SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic                    r_blank_q;

  logic                  w_tick;
  logic                  w_wrap;
  logic                  w_acc;
  logic [NUM_DIGITS-1:0] w_lz;
  logic [NUM_DIGITS-1:0] w_blank_mask;
  logic [NUM_DIGITS-1:0] w_an_hot;
  logic [3:0]            w_dig;
  logic                  w_blk;
  logic [6:0]            w_seg_hi;

  function automatic logic [6:0] f_decode(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  assign w_tick = (r_presc == P_LAST);
  assign w_wrap = (r_idx == I_LAST);

  // w_lz[k]: digit k and every digit above it are zero.
  // Digit 0 is never blanked so an all-zero value shows "0".
  always_comb begin
    w_acc = 1'b1;
    w_lz  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_acc   = w_acc && (r_shadow[4*k +: 4] == 4'd0);
      w_lz[k] = w_acc;
    end
    w_blank_mask    = w_lz & {NUM_DIGITS{r_blank_q}};
    w_blank_mask[0] = 1'b0;
  end

  always_comb begin
    w_an_hot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_an_hot[k] = (r_idx == IW'(k));
    end
  end

  assign w_dig    = r_shadow[{r_idx, 2'b00} +: 4];
  assign w_blk    = w_blank_mask[r_idx];
  assign w_seg_hi = w_blk ? 7'h00 : f_decode(w_dig);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_shadow    <= '0;
      r_blank_q   <= 1'b0;
      frame_start <= 1'b0;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
    end else begin
      frame_start <= 1'b0;
      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= w_wrap ? '0 : r_idx + IW'(1);
        // Snapshot only at the frame boundary so a frame never tears.
        if (w_wrap) begin
          r_shadow    <= digits_in;
          r_blank_q   <= blank_lz;
          frame_start <= 1'b1;
        end
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      an  <= AN_ACTIVE_LOW ? ~w_an_hot : w_an_hot;
      seg <= SEG_ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
    end
  end

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// tb_bcd_7seg_scan_driver: scoreboard bench for bcd_7seg_scan_driver
// with NUM_DIGITS=4, REFRESH_DIV=4, active-low outputs.
module tb_bcd_7seg_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits_in = 16'h0000;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_start;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_7seg_scan_driver #(
    .NUM_DIGITS(4),
    .REFRESH_DIV(4),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .digits_in(digits_in),
    .blank_lz(blank_lz),
    .seg(seg),
    .an(an),
    .frame_start(frame_start)
  );

  // Active-low segment pattern for digit k of value v.
  function automatic logic [6:0] model_seg(
    input logic [15:0] v,
    input logic        bl,
    input int          k
  );
    logic [15:0] above;
    logic [6:0]  hi;
    above = v >> (4 * k);
    if (bl && k != 0 && above == 16'h0) return 7'h7F;
    case (above[3:0])
      4'd0:    hi = 7'h3F;
      4'd1:    hi = 7'h06;
      4'd2:    hi = 7'h5B;
      4'd3:    hi = 7'h4F;
      4'd4:    hi = 7'h66;
      4'd5:    hi = 7'h6D;
      4'd6:    hi = 7'h7D;
      4'd7:    hi = 7'h07;
      4'd8:    hi = 7'h7F;
      4'd9:    hi = 7'h6F;
      default: hi = 7'h40;
    endcase
    return ~hi;
  endfunction

  // One frame: each digit held 4 cycles, frame_start on the last.
  task automatic push_frame(input logic [15:0] v, input logic bl);
    exp_t e;
    logic [3:0] one;
    one = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        e.an  = ~(one << k);
        e.seg = model_seg(v, bl, k);
        e.fs  = (k == 3 && c == 3);
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_fs(input string tag);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (frame_start !== 1'b1 && t < 64);
    n_checks++;
    if (frame_start !== 1'b1) begin
      n_errors++;
      $display("FAIL %s wait: frame_start=%b required 1",
               tag, frame_start);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    int   i;
    reset = 1'b1;
    digits_in = 16'h0000;
    blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({an, seg, frame_start} !== {4'hF, 7'h7F, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_hold: an=%b seg=%h fs=%b want 1111 7f 0",
               an, seg, frame_start);
    end
    reset = 1'b0;
    push_frame(16'h0000, 1'b0);
    i = 0;
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({an, seg, frame_start} !== e) begin
        n_errors++;
        $display("FAIL reset_frame[%0d]: an=%b seg=%h fs=%b want an=%b seg=%h fs=%b",
                 i, an, seg, frame_start, e.an, e.seg, e.fs);
      end
      i++;
    end
  endtask

  task automatic test_frame(
    input string       tag,
    input logic [15:0] v,
    input logic        bl
  );
    exp_t e;
    int   i;
    digits_in = v;
    blank_lz = bl;
    wait_fs(tag);
    push_frame(v, bl);
    i = 0;
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({an, seg, frame_start} !== e) begin
        n_errors++;
        $display("FAIL %s[%0d]: an=%b seg=%h fs=%b want an=%b seg=%h fs=%b",
                 tag, i, an, seg, frame_start, e.an, e.seg, e.fs);
      end
      i++;
    end
  endtask

  task automatic test_tear();
    exp_t e;
    int   i;
    test_frame("tear_pre", 16'h1111, 1'b0);
    push_frame(16'h1111, 1'b0);
    push_frame(16'h2222, 1'b0);
    i = 0;
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({an, seg, frame_start} !== e) begin
        n_errors++;
        $display("FAIL tear[%0d]: an=%b seg=%h fs=%b want an=%b seg=%h fs=%b",
                 i, an, seg, frame_start, e.an, e.seg, e.fs);
      end
      // digit 1 is being scanned here
      if (i == 4) digits_in = 16'h2222;
      i++;
    end
  endtask

  task automatic test_counter();
    int cnt;
    logic [3:0] c4;
    cnt = 0;
    for (int s = 0; s < 12; s++) begin
      c4 = cnt[3:0];
      test_frame("cnt_up", {12'h000, c4}, 1'b1);
      cnt = (cnt + 1) % 10;
    end
    for (int s = 0; s < 12; s++) begin
      cnt = (cnt + 9) % 10;
      c4 = cnt[3:0];
      test_frame("cnt_dn", {12'h000, c4}, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   i;
    digits_in = 16'h0009;
    blank_lz = 1'b1;
    wait_fs("mid_sync");
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({an, seg, frame_start} !== {4'hF, 7'h7F, 1'b0}) begin
      n_errors++;
      $display("FAIL mid_reset: an=%b seg=%h fs=%b want 1111 7f 0",
               an, seg, frame_start);
    end
    reset = 1'b0;
    push_frame(16'h0000, 1'b0);
    i = 0;
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({an, seg, frame_start} !== e) begin
        n_errors++;
        $display("FAIL mid_frame[%0d]: an=%b seg=%h fs=%b want an=%b seg=%h fs=%b",
                 i, an, seg, frame_start, e.an, e.seg, e.fs);
      end
      i++;
    end
  endtask

  initial begin
    test_reset();
    test_frame("digits_0123", 16'h0123, 1'b0);
    test_frame("blank_0007", 16'h0007, 1'b1);
    test_frame("blank_0000", 16'h0000, 1'b1);
    test_frame("blank_0305", 16'h0305, 1'b1);
    test_frame("nonbcd_a0f5", 16'hA0F5, 1'b0);
    test_tear();
    test_counter();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
